tanh_engine_arbiter: RTL and testbench
======================================

Name: tanh_engine_arbiter

Overview:
Shares one tanh CORDIC engine (hyperbolic stage followed by linear-divide stage) between NUM_REQ independent requesters.
- Arbitrates round-robin and latches the winner's operand.
- Sequences the engine: a one-cycle EN load pulse, then waits for done, with a stale-done guard and a timeout.
- Returns the result on a single tagged response channel with valid/ready handshake.
- Sits between the activation-function request sources and the tanh engine instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of response tag; must equal clog2(NUM_REQ)
MIN_LAT, 20, cycles after load before eng_done is believed (masks a stale done from the previous op)
TIMEOUT, 64, RUN cycles after which the op is aborted with error; must be > MIN_LAT

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_z  in  32*NUM_REQ  per-requester operand, IEEE-754 single; requester k in bits [32k+31:32k]
req_ready  out  NUM_REQ  one-hot grant/accept
eng_en  out  1  engine EN (load/reset pulse)
eng_z  out  32  engine operand
eng_out  in  32  engine tanh result
eng_done  in  1  engine done, level
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_data  out  32  tanh result, IEEE-754 single
resp_id  out  ID_W  index of the requester served
resp_err  out  1  1 = op timed out; resp_data is 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, applied while rst=1 at a clk edge:
  - state=IDLE; rr_ptr=0; cnt=0.
  - req_ready=0, eng_en=0, eng_z=0, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, busy=0.
  - req_ready is forced 0 combinationally while rst=1.
- Reset mid-operation: in-flight op is dropped with no response; engine is not pulsed; next op starts from IDLE with rr_ptr=0.
- States: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - Grant g = first k with req_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle, all other bits 0; no grant if no valid.
  - On handshake: eng_z<=req_z[g], resp_id<=g, rr_ptr<=(g+1) mod NUM_REQ, go LOAD.
- LOAD: eng_en=1 for exactly one cycle; cnt<=0; go RUN.
- RUN: eng_en=0; cnt increments every cycle, saturating at TIMEOUT-1.
  - If eng_done=1 and cnt>=MIN_LAT: resp_data<=eng_out, resp_err<=0, resp_valid<=1, go RESP.
  - Else if cnt==TIMEOUT-1: resp_data<=0, resp_err<=1, resp_valid<=1, go RESP.
  - eng_done and timeout in the same cycle: done wins, resp_err=0.
  - eng_done while cnt<MIN_LAT is ignored.
- RESP:
  - resp_valid, resp_data, resp_id, resp_err are held stable until resp_valid&resp_ready.
  - On handshake: resp_valid<=0, go IDLE. No new grant in the handshake cycle.
- eng_z is held from grant through RESP; it changes only at an IDLE handshake. req_ready is 0 in every non-IDLE state.
- Latency: handshake at cycle T; eng_en=1 at T+1; RUN cnt=0 at T+2. Done seen at cnt=n gives resp_valid=1 at T+3+n. Minimum op period is n+4 cycles with resp_ready tied 1.
- Fairness: a requester holding req_valid is served within NUM_REQ-1 other ops.
- Requester handshake convention: req_valid may drop without a grant; req_z is sampled only on grant.

Test Plan:
- Single request: req_valid[0]=1, req_z=0x3F000000. Stub engine raises done 34 cycles after the eng_en pulse with eng_out=0x3EEC9A9F, resp_ready=1 -> resp_valid one cycle after done, resp_data=0x3EEC9A9F, resp_id=0, resp_err=0, eng_en high exactly 1 cycle.
- Round-robin: all four req_valid held high, operands 0x3F800000/0x40000000/0xBF800000/0x3E800000 -> grant order 0,1,2,3,0. Each resp_id matches and each eng_z matches the granted operand.
- Stale done: stub holds eng_done=1 continuously from before the load and updates eng_out at cnt=30 -> response is captured at cnt=MIN_LAT=20 with the eng_out present then. Second case: done high only at cnt=5 then again at cnt=25 -> captured at cnt=25.
- Timeout: stub never raises done -> resp_valid at cnt=63 boundary, resp_err=1, resp_data=0. Same-cycle done at cnt=63 -> resp_err=0.
- Backpressure: resp_ready=0 for 10 cycles in RESP -> outputs stable, req_ready=0, no eng_en. Release -> IDLE, next grant one cycle later.
- Reset mid-RUN at cnt=10 -> all outputs at reset values next cycle, no response. After reset, a request on requester 2 is granted normally.

Source files
------------

// File: rtl/tanh_engine_arbiter.sv
// tanh_engine_arbiter: round-robin front end that shares a single tanh CORDIC
// engine between NUM_REQ requesters. A winner's operand is latched, the engine
// gets a one-cycle load pulse, its done level is trusted only after MIN_LAT
// cycles, and a stuck op is aborted after TIMEOUT cycles. Results leave on one
// tagged valid/ready response channel.
module tanh_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MIN_LAT = 20,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_z,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    eng_en,
  output logic [31:0]             eng_z,
  input  logic [31:0]             eng_out,
  input  logic                    eng_done,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int              CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_LAT);
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      z_arr [NUM_REQ];
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W:0]    scan_idx;
  logic             take;
  logic             done_ok;
  logic             timed_out;

  // Split the flat operand bus into one word per requester.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign z_arr[k] = req_z[32*k +: 32];
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      if (scan_idx >= NUM_REQ_X) begin
        scan_idx = scan_idx - NUM_REQ_X;
      end
      if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // A grant is only offered in IDLE and never while reset is held.
  assign take      = (state == IDLE) && grant_found && !rst;
  assign done_ok   = eng_done && (cnt >= CNT_MIN);
  assign timed_out = (cnt == CNT_MAX);
  assign busy      = (state != IDLE);
  assign eng_en    = (state == LOAD) && !rst;

  // One-hot accept toward the winning requester.
  always_comb begin
    req_ready = '0;
    if (take) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic; a valid done wins over a same-cycle timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (take) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN:  if (done_ok || timed_out) state_next = RESP;
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand/tag capture, run counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      cnt        <= '0;
      eng_z      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            eng_z   <= z_arr[grant_idx];
            resp_id <= grant_idx;
            rr_ptr  <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
          end
        end
        LOAD: begin
          cnt <= '0;
        end
        RUN: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (done_ok) begin
            resp_data  <= eng_out;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end else if (timed_out) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_engine_arbiter.sv
// tb_tanh_engine_arbiter: drives tanh_engine_arbiter with a stub tanh engine
// whose done/result behaviour is configured per operation, comparing against
// hand-derived table entries and a behavioural model for random operations.
module tb_tanh_engine_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MIN_LAT = 20;
  localparam int TIMEOUT = 64;

  localparam int M_LAT    = 0;
  localparam int M_ALWAYS = 1;
  localparam int M_PULSE  = 2;
  localparam int M_NEVER  = 3;

  typedef struct {
    logic             do_reset;
    logic [3:0]       valid;
    logic [3:0][31:0] z;
    int               mode;
    int               lat;
    int               p1;
    int               p2;
    logic [31:0]      out_a;
    logic [31:0]      out_b;
    int               sw;
    int               bp;
    int               exp_id;
    int               exp_cnt;
    logic             exp_err;
    logic [31:0]      exp_data;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [32*NUM_REQ-1:0] req_z = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  eng_en;
  logic [31:0]           eng_z;
  logic [31:0]           eng_out;
  logic                  eng_done;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [31:0]           resp_data;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_err;
  logic                  busy;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   tcnt        = 1000;
  int   mptr        = 0;
  vec_t cur;
  vec_t tbl [12];

  tanh_engine_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
    .eng_en(eng_en), .eng_z(eng_z), .eng_out(eng_out), .eng_done(eng_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter and stub engine timer, restarted by each load pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_en) tcnt <= 0;
    else        tcnt <= tcnt + 1;
  end

  function automatic logic stub_done(input vec_t v, input int c);
    case (v.mode)
      M_LAT:    return c >= v.lat;
      M_ALWAYS: return 1'b1;
      M_PULSE:  return (c == v.p1) || (c == v.p2);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] stub_out(input vec_t v, input int c);
    return (c >= v.sw) ? v.out_b : v.out_a;
  endfunction

  // Stub engine outputs as a function of cycles since load.
  always_comb begin
    eng_done = stub_done(cur, tcnt);
    eng_out  = stub_out(cur, tcnt);
  end

  function automatic vec_t mk(input logic rs, input logic [3:0] va,
                              input logic [3:0][31:0] z, input int mo, input int la,
                              input int q1, input int q2, input logic [31:0] oa,
                              input logic [31:0] ob, input int s, input int b,
                              input int eid, input int ec, input logic ee,
                              input logic [31:0] ed);
    vec_t v;
    v.do_reset = rs; v.valid = va; v.z = z; v.mode = mo; v.lat = la;
    v.p1 = q1; v.p2 = q2; v.out_a = oa; v.out_b = ob; v.sw = s; v.bp = b;
    v.exp_id = eid; v.exp_cnt = ec; v.exp_err = ee; v.exp_data = ed;
    return v;
  endfunction

  // Reference: round-robin pick from the pointer, then the first RUN count at
  // or after MIN_LAT where done is high, else a timeout at TIMEOUT-1.
  function automatic int model_grant(input logic [3:0] va, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (va[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_result(input vec_t v, output int c_o, output logic e_o,
                              output logic [31:0] d_o);
    c_o = TIMEOUT - 1; e_o = 1'b1; d_o = '0;
    for (int c = MIN_LAT; c < TIMEOUT; c++) begin
      if (stub_done(v, c)) begin
        c_o = c; e_o = 1'b0; d_o = stub_out(v, c);
        break;
      end
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] b);
    for (int k = 0; k < NUM_REQ; k++) if (b[k]) return k;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.valid;
    req_z      = v.z;
    cur        = v;
    resp_ready = (v.bp == 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask

  task automatic runOp(input vec_t v, input int exp_id, input int exp_cnt,
                       input logic exp_err, input logic [31:0] exp_data);
    int waited, t0, en_cnt, bad_ready;
    logic got, stable;
    logic [31:0] h_data;
    logic [ID_W-1:0] h_id;
    logic h_err;
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput("resp_cleared", resp_valid, 0);
    waited = 0;
    while (req_ready == '0 && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    checkOutput("grant_wait", waited, 0);
    checkOutput("grant_onehot", $countones(req_ready), 1);
    checkOutput("grant_id", onehot_idx(req_ready), exp_id);
    t0 = cyc;
    @(negedge clk);
    checkOutput("load_en", eng_en, 1);
    checkOutput("eng_z", eng_z, v.z[exp_id]);
    checkOutput("busy", busy, 1);
    got = 1'b0; en_cnt = 0; bad_ready = 0;
    for (int i = 0; i < TIMEOUT + 20 && !got; i++) begin
      @(negedge clk);
      if (eng_en) en_cnt++;
      if (req_ready != '0) bad_ready++;
      if (resp_valid) got = 1'b1;
    end
    checkOutput("resp_seen", got, 1);
    if (!got) return;
    checkOutput("latency", cyc - t0, 3 + exp_cnt);
    checkOutput("resp_data", resp_data, exp_data);
    checkOutput("resp_id", resp_id, exp_id);
    checkOutput("resp_err", resp_err, exp_err);
    checkOutput("extra_en", en_cnt, 0);
    checkOutput("ready_in_op", bad_ready, 0);
    checkOutput("eng_z_held", eng_z, v.z[exp_id]);
    h_data = resp_data; h_id = resp_id; h_err = resp_err;
    for (int i = 0; i < v.bp; i++) begin
      @(negedge clk);
      stable = resp_valid && (resp_data == h_data) && (resp_id == h_id) &&
               (resp_err == h_err) && (req_ready == '0) && !eng_en && busy;
      checkOutput("bp_stable", stable, 1);
    end
    resp_ready = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, table vectors, reset mid-run, random ops.
  initial begin
    logic [3:0][31:0] zs, z1;
    vec_t v;
    int eid, ec;
    logic ee;
    logic [31:0] ed;
    zs = {32'h3E800000, 32'hBF800000, 32'h40000000, 32'h3F800000};
    z1 = {32'h3E800000, 32'hBF800000, 32'h40000000, 32'h3F000000};
    cur = mk(0, 4'b0, zs, M_NEVER, 0, 0, 0, 0, 0, 1000, 0, 0, 0, 0, 0);

    tbl[0]  = mk(0, 4'b0001, z1, M_LAT, 33, 0, 0, 32'h3EEC9A9F, 0, 1000, 0, 0, 33, 0, 32'h3EEC9A9F);
    tbl[1]  = mk(1, 4'b1111, zs, M_LAT, 20, 0, 0, 32'h3F42F7D6, 0, 1000, 0, 0, 20, 0, 32'h3F42F7D6);
    tbl[2]  = mk(0, 4'b1111, zs, M_LAT, 20, 0, 0, 32'h3F76CA83, 0, 1000, 0, 1, 20, 0, 32'h3F76CA83);
    tbl[3]  = mk(0, 4'b1111, zs, M_LAT, 22, 0, 0, 32'hBF42F7D6, 0, 1000, 0, 2, 22, 0, 32'hBF42F7D6);
    tbl[4]  = mk(0, 4'b1111, zs, M_LAT, 20, 0, 0, 32'h3E7AD570, 0, 1000, 0, 3, 20, 0, 32'h3E7AD570);
    tbl[5]  = mk(0, 4'b1111, zs, M_LAT, 25, 0, 0, 32'h3F42F7D6, 0, 1000, 0, 0, 25, 0, 32'h3F42F7D6);
    tbl[6]  = mk(0, 4'b0010, zs, M_ALWAYS, 0, 0, 0, 32'h11111111, 32'h22222222, 30, 0, 1, 20, 0, 32'h11111111);
    tbl[7]  = mk(0, 4'b0100, zs, M_PULSE, 0, 5, 25, 32'hAAAA0000, 32'hBBBB0000, 25, 0, 2, 25, 0, 32'hBBBB0000);
    tbl[8]  = mk(0, 4'b1000, zs, M_NEVER, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 3, 63, 1, 32'h0);
    tbl[9]  = mk(0, 4'b0001, zs, M_PULSE, 0, 63, 63, 32'h12345678, 0, 1000, 0, 0, 63, 0, 32'h12345678);
    tbl[10] = mk(0, 4'b0011, zs, M_LAT, 21, 0, 0, 32'h0BADF00D, 0, 1000, 10, 1, 21, 0, 32'h0BADF00D);
    tbl[11] = mk(0, 4'b0101, zs, M_PULSE, 0, 19, 40, 32'h5555AAAA, 0, 1000, 0, 2, 40, 0, 32'h5555AAAA);

    rst = 1'b1;
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_en", eng_en, 0);
    checkOutput("rst_eng_z", eng_z, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_data", resp_data, 0);
    checkOutput("rst_resp_id", resp_id, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_busy", busy, 0);
    req_valid = '0;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_reset) doReset();
      runOp(tbl[i], tbl[i].exp_id, tbl[i].exp_cnt, tbl[i].exp_err, tbl[i].exp_data);
    end

    v = mk(0, 4'b0010, zs, M_LAT, 50, 0, 0, 32'h77777777, 0, 1000, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput("mid_grant", onehot_idx(req_ready), 1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_ready", req_ready, 0);
    checkOutput("mid_en", eng_en, 0);
    checkOutput("mid_eng_z", eng_z, 0);
    checkOutput("mid_resp_valid", resp_valid, 0);
    checkOutput("mid_resp_data", resp_data, 0);
    checkOutput("mid_resp_id", resp_id, 0);
    checkOutput("mid_resp_err", resp_err, 0);
    checkOutput("mid_busy", busy, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checkOutput("dropped_resp", {30'b0, resp_valid, eng_en}, 0);
    end

    v = mk(0, 4'b0101, zs, M_LAT, 30, 0, 0, 32'h3F3F3F3F, 0, 1000, 0, 0, 0, 0, 0);
    eid = model_grant(v.valid, mptr);
    model_result(v, ec, ee, ed);
    runOp(v, eid, ec, ee, ed);
    mptr = (eid + 1) % NUM_REQ;
    v.valid = 4'b0100;
    eid = model_grant(v.valid, mptr);
    runOp(v, eid, ec, ee, ed);
    mptr = (eid + 1) % NUM_REQ;

    for (int n = 0; n < 40; n++) begin
      v.do_reset = 1'b0;
      v.valid = 4'($urandom_range(1, 15));
      for (int k = 0; k < NUM_REQ; k++) v.z[k] = $urandom;
      v.mode  = $urandom_range(0, 3);
      v.lat   = $urandom_range(0, 70);
      v.p1    = $urandom_range(0, 70);
      v.p2    = $urandom_range(0, 70);
      v.out_a = $urandom;
      v.out_b = $urandom;
      v.sw    = $urandom_range(0, 70);
      v.bp    = $urandom_range(0, 3);
      eid = model_grant(v.valid, mptr);
      model_result(v, ec, ee, ed);
      runOp(v, eid, ec, ee, ed);
      mptr = (eid + 1) % NUM_REQ;
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
